// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the multiply sequencer and its HI/LO pair.
package muldiv_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int MULT_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ITER    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // The counter has to hold MULT_CYCLES itself, hence the +1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(MULT_CYCLES_DEF);

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO pair: a product capture overrides MTHI/MTLO writes; rd_sel picks the read port.
module hilo_regs #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_hi,
  input  logic [DATA_W-1:0] cap_lo,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (cap_en) begin
      r_hi <= cap_hi;
      r_lo <= cap_lo;
    end else begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = rd_sel ? r_hi : r_lo;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multiplier sequencer with HI/LO capture, MTHI/MTLO writes and MFHI/MFLO stall; start->done is MULT_CYCLES+3.
// MULDIV_FWD_EN: forward the multiplier result to rd_data during CAPTURE and drop the stall there.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mult_ctrl,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              busy,
  output logic              done,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = cnt_width(MULT_CYCLES);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_cap;
  logic            w_pre_cap;
  logic [DATA_W-1:0] w_rd_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (r_state == ST_LOAD)      r_cnt <= CW'(MULT_CYCLES);
      else if (r_state == ST_ITER) r_cnt <= r_cnt - CW'(1);
      r_done <= (r_state == ST_CAPTURE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_ITER;
      ST_ITER:    if (r_cnt == CW'(1)) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mult_ctrl = (r_state == ST_LOAD);
    w_pre_cap = (r_state == ST_LOAD) || (r_state == ST_ITER);
    w_cap     = (r_state == ST_CAPTURE);
    busy      = w_pre_cap || w_cap;
  end

  // MTHI/MTLO are dropped for the whole multiply, so the product always wins.
  hilo_regs #(.DATA_W(DATA_W)) u_hilo (
    .clk     (clk),
    .reset   (reset),
    .cap_en  (w_cap),
    .cap_hi  (mult_hi),
    .cap_lo  (mult_lo),
    .hi_we   (hi_we & ~busy),
    .lo_we   (lo_we & ~busy),
    .wdata   (wdata),
    .rd_sel  (rd_sel),
    .hi      (hi),
    .lo      (lo),
    .rd_data (w_rd_reg)
  );

`ifdef MULDIV_FWD_EN
  assign rd_data   = w_cap ? (rd_sel ? mult_hi : mult_lo) : w_rd_reg;
  assign stall_req = rd_req & w_pre_cap;
`else
  assign rd_data   = w_rd_reg;
  assign stall_req = rd_req & busy;
`endif

  assign done = r_done;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized bench: cycle-indexed reference model of the multiply timeline plus a behavioural multiplier.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, rd_req, rd_sel;
  logic [31:0] mult_hi, mult_lo, wdata, rd_data, hi, lo;
  logic        mult_ctrl, busy, done, stall_req;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mult_ctrl(mult_ctrl),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .busy(busy), .done(done),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_data(rd_data), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: position of the current cycle relative to the accepted start.
  int          cyc = 0;
  int          t_start = -1000;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_prod = '0;
  logic [31:0] op_a = '0, op_b = '0;
  int          n_done = 0;

  // Behavioural shift-add multiplier: result valid only after exactly 32 iterations.
  logic [31:0] mu_a = '0, mu_b = '0;
  int          mu_iter = 1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] prod_of(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic step();
    int          k;
    bit          bz, mc;
    logic [31:0] e_rd;
    bit          e_stall;
    logic [63:0] mp;
    @(negedge clk);
    k       = cyc - t_start;
    bz      = (k >= 1 && k <= 34);
    e_rd    = rd_sel ? m_hi : m_lo;
    e_stall = rd_req && bz;
`ifdef MULDIV_FWD_EN
    if (k == 34) begin
      e_rd    = rd_sel ? m_prod[63:32] : m_prod[31:0];
      e_stall = 1'b0;
    end
`endif
    chk("busy", busy, bz);
    chk("mult_ctrl", mult_ctrl, k == 1);
    chk("done", done, k == 35);
    chk("stall_req", stall_req, e_stall);
    chk("rd_data", rd_data, e_rd);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (done) n_done++;
    mc = mult_ctrl;
    if (k == 34) begin
      m_hi = m_prod[63:32];
      m_lo = m_prod[31:0];
    end else if (!bz) begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
    end
    if (start && !bz) begin
      t_start = cyc;
      m_prod  = prod_of(op_a, op_b);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (mc) begin
      mu_a = op_a; mu_b = op_b; mu_iter = 0;
    end else if (mu_iter < 1000) begin
      mu_iter++;
    end
    mp      = prod_of(mu_a, mu_b);
    mult_hi = (mu_iter == 32) ? mp[63:32] : $urandom;
    mult_lo = (mu_iter == 32) ? mp[31:0]  : $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rd_req = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mult_ctrl", mult_ctrl, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    t_start = -1000;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
    repeat (36) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    rd_req = 1'b0; rd_sel = 1'b0; wdata = '0;
    mult_hi = $urandom; mult_lo = $urandom;
    #2;
    do_reset();

    // 7 x -3 with an MFHI pending for the whole multiply
    rd_req = 1'b1; rd_sel = 1'b1; n_done = 0;
    run_mul(32'd7, 32'hFFFF_FFFD);
    chk("hi_7xm3", hi, 32'hFFFF_FFFF);
    chk("lo_7xm3", lo, 32'hFFFF_FFEB);
    chk("done_once_a", n_done, 1);

    // Max positive squared, with a second start at cycle 5 that must be ignored
    rd_req = 1'b0; n_done = 0;
    op_a = 32'h7FFF_FFFF; op_b = 32'h7FFF_FFFF; start = 1'b1;
    step();
    for (int i = 1; i <= 36; i++) begin
      start = (i == 5);
      step();
    end
    start = 1'b0;
    chk("hi_max", hi, 32'h3FFF_FFFF);
    chk("lo_max", lo, 32'h0000_0001);
    chk("done_once_b", n_done, 1);

    // MTLO while idle, then ignored during ITER
    lo_we = 1'b1; wdata = 32'h1234_5678;
    step();
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'h1234_5678);
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    lo_we = 1'b0;
    chk("mtlo_busy", lo, 32'h1234_5678);
    repeat (32) step();
    chk("lo_3x5", lo, 32'd15);

    // MTHI in the same cycle as start: lands, then the product overwrites it
    op_a = 32'd2; op_b = 32'd3; hi_we = 1'b1; start = 1'b1; wdata = 32'hAAAA_5555;
    step();
    hi_we = 1'b0; start = 1'b0;
    chk("mthi_with_start", hi, 32'hAAAA_5555);
    repeat (36) step();
    chk("hi_after_cap", hi, 32'h0);
    chk("lo_2x3", lo, 32'd6);

    // Reset in cycle 10 of a multiply: abort, no done pulse afterwards
    op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    do_reset();
    rd_req = 1'b0; n_done = 0;
    repeat (40) step();
    chk("no_done_after_rst", n_done, 0);
    run_mul(32'h0001_0000, 32'h0001_0000);
    chk("hi_after_rst", hi, 32'h1);
    chk("lo_after_rst", lo, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kn;
      kn = cyc - t_start;
      start = ($urandom_range(0, 15) == 0);
      if (!(kn >= 1 && kn <= 34)) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      hi_we  = ($urandom_range(0, 7) == 0);
      lo_we  = ($urandom_range(0, 7) == 0);
      wdata  = $urandom;
      rd_req = $urandom_range(0, 1);
      rd_sel = $urandom_range(0, 1);
      step();
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Sequencer and architectural HI/LO register pair that sits directly downstream of the 32-bit shift-add multiplier. It turns a one-cycle start request from the main control unit into the multiplier's load/iterate control. It counts the iteration cycles and captures the multiplier's 64-bit result into HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes, stalling the pipeline while a product is in flight.

Parameters:
DATA_W, 32, width of each operand, HI and LO
MULT_CYCLES, 32, iteration edges the multiplier needs after its load edge (one per operand bit)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low; clock clk
start  in  1  one-cycle request to begin a multiply (operands already on the multiplier's srcA/srcB)
mult_ctrl  out  1  to multiplier multCtrl: 1 = load operands, 0 = iterate
mult_hi  in  DATA_W  multiplier hi output
mult_lo  in  DATA_W  multiplier lo output
busy  out  1  multiply in flight (states LOAD, ITER, CAPTURE)
done  out  1  one-cycle pulse; new HI/LO visible this cycle
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  DATA_W  MTHI/MTLO write data
rd_req  in  1  MFHI/MFLO read request
rd_sel  in  1  0 = LO, 1 = HI
rd_data  out  DATA_W  selected register value (combinational)
stall_req  out  1  pipeline stall request (combinational)
hi  out  DATA_W  architectural HI
lo  out  DATA_W  architectural LO

Behaviour:
- Reset (async, on reset low): state=IDLE, cnt=0, hi=0, lo=0, done=0, mult_ctrl=0. busy=0 and stall_req=0 follow from state.
- FSM states:
  - IDLE: start=1 -> LOAD.
  - LOAD: mult_ctrl=1 for exactly this cycle; cnt<=MULT_CYCLES; -> ITER.
  - ITER: mult_ctrl=0; cnt decrements each edge; when cnt==1 at the edge -> CAPTURE.
  - CAPTURE: at the end edge, hi<=mult_hi and lo<=mult_lo; done<=1; -> IDLE.
- Timing: start sampled at edge E0 -> LOAD in cycle 1 -> ITER in cycles 2..33 (32 iteration edges) -> CAPTURE in cycle 34. done=1 and new hi/lo are visible in cycle 35. Fixed latency start->done = MULT_CYCLES+3 cycles.
- mult_ctrl is 0 in every state except LOAD. The multiplier keeps shifting while idle; this is harmless and never captured.
- start while busy=1: ignored, no restart.
- hi_we/lo_we:
  - Honoured only when busy=0; hi/lo update at the next edge.
  - Ignored while busy; the product always wins.
  - hi_we and start in the same IDLE cycle: the write lands, then the product overwrites it in CAPTURE.
- rd_data = rd_sel ? hi : lo, always driven.
- stall_req = rd_req & busy.
- Reset mid-operation: abort immediately; hi/lo=0; no done pulse; the next start runs the full sequence.
- cnt width = clog2(MULT_CYCLES+1).

Optional Feature:
MULDIV_FWD_EN:
- Defined: in CAPTURE, rd_data forwards mult_hi/mult_lo per rd_sel, and stall_req = rd_req & (state==LOAD|ITER). An MFHI/MFLO in the capture cycle therefore proceeds without stalling.
- Undefined: stall_req covers CAPTURE too, and rd_data always comes from the hi/lo registers.

Decomposition:
- Package muldiv_pkg holds:
  - state enum (IDLE, LOAD, ITER, CAPTURE)
  - DATA_W and MULT_CYCLES defaults
  - counter-width constant
- One sub-module, hilo_regs: the HI/LO register pair with async reset, write-enable muxing (capture vs MTHI/MTLO, capture priority) and the rd_sel read mux.

Test Plan:
- Reset low mid-ITER (cycle 10 after start) -> state IDLE, hi=lo=0, busy=0; no done pulse follows.
- Multiply 7 x 0xFFFFFFFD (-3): start at E0 -> mult_ctrl=1 only in cycle 1, busy cycles 1..34, done=1 in cycle 35 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Multiply 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; second start at cycle 5 is ignored (done still in cycle 35, exactly once).
- MTLO wdata=0x12345678 while idle -> lo=0x12345678 next cycle. Same write during ITER -> lo unchanged until CAPTURE loads the product.
- rd_req=1, rd_sel=1 throughout a multiply:
  - without MULDIV_FWD_EN, stall_req=1 cycles 1..34 and rd_data equals the product from cycle 35;
  - with MULDIV_FWD_EN, stall_req=1 cycles 1..33 and rd_data=mult_hi in cycle 34.
